vdp_sprite_line_scanner: RTL and testbench

//  Parametrised successor to the sprite raster-collision stage. Once per line it scans SPRITE_COUNT y_block entries,

---
 rtl/vdp_sprite_line_scanner_pkg.sv | 35 +++
 rtl/vdp_sprite_line_scanner_if.sv | 28 ++
 rtl/vdp_sprite_line_scanner_y_test.sv | 46 ++++
 rtl/vdp_sprite_line_scanner.sv | 146 ++++++++++++++
 tb/tb_vdp_sprite_line_scanner.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_sprite_line_scanner_pkg.sv
// Shared types and field-layout helpers for the sprite line scanner.
// VDP_SPRITE_OVERFLOW_STATUS_EN (in the top) selects live hit_count/overflow status.
package vdp_sprite_line_scanner_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StTerm
    } scan_state_e;

    localparam int unsigned MinHeight = 8;

    function automatic int unsigned ofs_width(int unsigned max_height_sel);
        return 3 + max_height_sel;
    endfunction

    // Hit entry layout, MSB first: {T, width_sel[1:0], line_offset, sprite_id}
    function automatic int unsigned hit_width(int unsigned id_w, int unsigned max_height_sel);
        return 1 + 2 + ofs_width(max_height_sel) + id_w;
    endfunction

    // y_block field positions move with the Y field width
    function automatic int unsigned flip_bit(int unsigned y_w);
        return y_w;
    endfunction

    function automatic int unsigned hsel_lsb(int unsigned y_w);
        return y_w + 1;
    endfunction

    function automatic int unsigned wsel_lsb(int unsigned y_w);
        return y_w + 3;
    endfunction

endpackage

// File: rtl/vdp_sprite_line_scanner_if.sv
// y_block read port and hit list write port between scanner (master) and memories (slave).
interface vdp_sprite_line_scanner_if #(
    parameter int unsigned ID_W  = 8,
    parameter int unsigned HC_W  = 7,
    parameter int unsigned HIT_W = 17
);
    logic [ID_W-1:0]  meta_addr;
    logic [15:0]      meta_data;
    logic             hit_we;
    logic [HC_W-1:0]  hit_addr;
    logic [HIT_W-1:0] hit_data;

    modport master (
        output meta_addr,
        input  meta_data,
        output hit_we,
        output hit_addr,
        output hit_data
    );

    modport slave (
        input  meta_addr,
        output meta_data,
        input  hit_we,
        input  hit_addr,
        input  hit_data
    );
endinterface

// File: rtl/vdp_sprite_line_scanner_y_test.sv
// Combinational vertical test of one y_block word against the render line:
// wrapped row distance, clamped height, hit flag and (optionally flipped) line offset.
module vdp_sprite_line_scanner_y_test
    import vdp_sprite_line_scanner_pkg::*;
#(
    parameter int unsigned Y_W            = 9,
    parameter int unsigned MAX_HEIGHT_SEL = 3,
    localparam int unsigned OFS_W         = ofs_width(MAX_HEIGHT_SEL)
) (
    input  logic [Y_W-1:0]   render_y,
    input  logic [15:0]      meta_data,
    output logic             hit,
    output logic [OFS_W-1:0] line_offset,
    output logic [1:0]       width_sel
);

    localparam int unsigned FlipBit = flip_bit(Y_W);
    localparam int unsigned HselLsb = hsel_lsb(Y_W);
    localparam int unsigned WselLsb = wsel_lsb(Y_W);

    logic [Y_W-1:0] y;
    logic [Y_W-1:0] dy;
    logic           flip;
    logic [1:0]     sel_raw;
    logic [1:0]     sel;
    logic [15:0]    height;

    always_comb begin
        y         = meta_data[Y_W-1:0];
        flip      = meta_data[FlipBit];
        sel_raw   = meta_data[HselLsb +: 2];
        width_sel = meta_data[WselLsb +: 2];
        sel       = (32'(sel_raw) > MAX_HEIGHT_SEL) ? 2'(MAX_HEIGHT_SEL) : sel_raw;
        // Subtraction at Y_W bits gives the intended wrap for sprites straddling the top edge
        dy        = render_y - y;
        height    = 16'(MinHeight) << sel;
        hit       = 16'(dy) < height;
        line_offset = flip ? (OFS_W'(height - 16'd1) - OFS_W'(dy)) : OFS_W'(dy);
    end

    if (Y_W + 5 < 16) begin : g_spare_bits
        logic unused_meta_hi;
        assign unused_meta_hi = ^meta_data[15:Y_W+5];
    end

endmodule

// File: rtl/vdp_sprite_line_scanner.sv
// Per-line sprite scanner: reads every y_block entry, writes a capped, terminated hit list.
// VDP_SPRITE_OVERFLOW_STATUS_EN: when defined, hit_count and sticky overflow are live outputs.
module vdp_sprite_line_scanner
    import vdp_sprite_line_scanner_pkg::*;
#(
    parameter int unsigned SPRITE_COUNT   = 256,
    parameter int unsigned MAX_HITS       = 64,
    parameter int unsigned Y_W            = 9,
    parameter int unsigned MAX_HEIGHT_SEL = 3,
    localparam int unsigned ID_W          = $clog2(SPRITE_COUNT),
    localparam int unsigned HC_W          = $clog2(MAX_HITS + 1),
    localparam int unsigned OFS_W         = ofs_width(MAX_HEIGHT_SEL),
    localparam int unsigned HIT_W         = hit_width(ID_W, MAX_HEIGHT_SEL)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [Y_W-1:0]            render_y,
    vdp_sprite_line_scanner_if.master bus,
    output logic                      busy,
    output logic [HC_W-1:0]           hit_count,
    output logic                      overflow
);

    localparam logic [ID_W-1:0]  LastId    = ID_W'(SPRITE_COUNT - 1);
    localparam logic [HC_W-1:0]  CapCount  = HC_W'(MAX_HITS);
    localparam logic [HIT_W-1:0] TermEntry = HIT_W'(1) << (HIT_W - 1);

    scan_state_e      state_q;
    logic [Y_W-1:0]   ry_q;
    logic [ID_W-1:0]  meta_addr_q;
    logic             issue_done_q;
    logic             test_vld_q;
    logic [ID_W-1:0]  test_id_q;
    logic [HC_W-1:0]  cnt_q;
    logic             hit_we_q;
    logic [HC_W-1:0]  hit_addr_q;
    logic [HIT_W-1:0] hit_data_q;
    logic             busy_q;
`ifdef VDP_SPRITE_OVERFLOW_STATUS_EN
    logic             ovf_q;
`endif

    logic             test_hit;
    logic [OFS_W-1:0] test_ofs;
    logic [1:0]       test_wsel;

    vdp_sprite_line_scanner_y_test #(
        .Y_W            (Y_W),
        .MAX_HEIGHT_SEL (MAX_HEIGHT_SEL)
    ) u_y_test (
        .render_y    (ry_q),
        .meta_data   (bus.meta_data),
        .hit         (test_hit),
        .line_offset (test_ofs),
        .width_sel   (test_wsel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            ry_q         <= '0;
            meta_addr_q  <= '0;
            issue_done_q <= 1'b0;
            test_vld_q   <= 1'b0;
            test_id_q    <= '0;
            cnt_q        <= '0;
            hit_we_q     <= 1'b0;
            hit_addr_q   <= '0;
            hit_data_q   <= '0;
            busy_q       <= 1'b0;
`ifdef VDP_SPRITE_OVERFLOW_STATUS_EN
            ovf_q        <= 1'b0;
`endif
        end else if (start) begin
            // Restart from any state; clearing test_vld_q drops the read still in flight
            state_q      <= StScan;
            ry_q         <= render_y;
            meta_addr_q  <= '0;
            issue_done_q <= 1'b0;
            test_vld_q   <= 1'b0;
            cnt_q        <= '0;
            hit_we_q     <= 1'b0;
            busy_q       <= 1'b1;
`ifdef VDP_SPRITE_OVERFLOW_STATUS_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            hit_we_q <= 1'b0;
            case (state_q)
                StIdle: ;
                StScan: begin
                    test_vld_q <= !issue_done_q;
                    test_id_q  <= meta_addr_q;
                    if (meta_addr_q == LastId) begin
                        issue_done_q <= 1'b1;
                    end else begin
                        meta_addr_q <= meta_addr_q + ID_W'(1);
                    end
                    if (test_vld_q) begin
                        if (test_hit && cnt_q == CapCount) begin
                            state_q <= StTerm;
`ifdef VDP_SPRITE_OVERFLOW_STATUS_EN
                            ovf_q   <= 1'b1;
`endif
                        end else begin
                            if (test_hit) begin
                                hit_we_q   <= 1'b1;
                                hit_addr_q <= cnt_q;
                                hit_data_q <= {1'b0, test_wsel, test_ofs, test_id_q};
                                cnt_q      <= cnt_q + HC_W'(1);
                            end
                            if (test_id_q == LastId) begin
                                state_q <= StTerm;
                            end
                        end
                    end
                end
                StTerm: begin
                    hit_we_q   <= 1'b1;
                    hit_addr_q <= cnt_q;
                    hit_data_q <= TermEntry;
                    busy_q     <= 1'b0;
                    test_vld_q <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.meta_addr = meta_addr_q;
    assign bus.hit_we    = hit_we_q;
    assign bus.hit_addr  = hit_addr_q;
    assign bus.hit_data  = hit_data_q;
    assign busy          = busy_q;

`ifdef VDP_SPRITE_OVERFLOW_STATUS_EN
    assign hit_count = cnt_q;
    assign overflow  = ovf_q;
`else
    assign hit_count = '0;
    assign overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_vdp_sprite_line_scanner.sv
// Scoreboard bench for the sprite line scanner: a line-level model queues expected hit list
// writes at each start, and a monitor compares every hit_we against the queue.
module tb_vdp_sprite_line_scanner;

    localparam int SC    = 64;
    localparam int MH    = 8;
    localparam int YW    = 9;
    localparam int MHS   = 3;
    localparam int ID_W  = $clog2(SC);
    localparam int HC_W  = $clog2(MH + 1);
    localparam int OFS_W = 3 + MHS;
    localparam int HIT_W = 3 + OFS_W + ID_W;
    localparam int YMOD  = 1 << YW;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [YW-1:0]   render_y;
    logic            busy;
    logic [HC_W-1:0] hit_count;
    logic            overflow;

    logic [15:0] ymem [SC];
    exp_t        exp_q[$];
    int          exp_n;
    int          exp_ovf;
    int          wr_cnt;
    int          checks   = 0;
    int          failures = 0;

    vdp_sprite_line_scanner_if #(.ID_W(ID_W), .HC_W(HC_W), .HIT_W(HIT_W)) bus_if ();

    vdp_sprite_line_scanner #(
        .SPRITE_COUNT   (SC),
        .MAX_HITS       (MH),
        .Y_W            (YW),
        .MAX_HEIGHT_SEL (MHS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .render_y  (render_y),
        .bus       (bus_if),
        .busy      (busy),
        .hit_count (hit_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // y_block RAM with one cycle read latency
    always @(posedge clk) bus_if.meta_data <= ymem[bus_if.meta_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (bus_if.hit_we) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%h", bus_if.hit_addr,
                         bus_if.hit_data);
            end else begin
                e = exp_q.pop_front();
                if (int'(bus_if.hit_addr) != e.addr || int'(bus_if.hit_data) != e.data) begin
                    failures++;
                    $display("FAIL hit_write actual addr=%0d data=%h expected addr=%0d data=%h",
                             bus_if.hit_addr, bus_if.hit_data, e.addr, e.data);
                end
            end
        end
    end

    // Line-level reference: walk sprites in id order, keep the first MH hits, then terminate
    task automatic build_expected(input int ry);
        int n;
        int ovf;
        n   = 0;
        ovf = 0;
        exp_q.delete();
        for (int id = 0; id < SC; id++) begin
            int y, flip, sel, w, h, dy, ofs;
            y    = ymem[id] % YMOD;
            flip = (ymem[id] >> YW) & 1;
            sel  = (ymem[id] >> (YW + 1)) & 3;
            w    = (ymem[id] >> (YW + 3)) & 3;
            if (sel > MHS) sel = MHS;
            h  = 8 << sel;
            dy = (ry - y + YMOD) % YMOD;
            if (dy < h) begin
                if (n == MH) begin
                    ovf = 1;
                    break;
                end
                ofs = flip ? (h - 1 - dy) : dy;
                exp_q.push_back('{addr: n, data: (w << (OFS_W + ID_W)) | (ofs << ID_W) | id});
                n++;
            end
        end
        exp_q.push_back('{addr: n, data: 1 << (HIT_W - 1)});
        exp_n   = n;
        exp_ovf = ovf;
    endtask

    task automatic set_spr(input int id, input int y, input int flip, input int sel, input int w);
        ymem[id] = 16'(((w & 3) << (YW + 3)) | ((sel & 3) << (YW + 1)) | ((flip & 1) << YW)
                       | (y % YMOD));
    endtask

    task automatic fill_off(input int y);
        for (int i = 0; i < SC; i++) set_spr(i, y, i & 1, i & 3, i & 3);
    endtask

    task automatic fill_random(input int ry, input int dens);
        for (int i = 0; i < SC; i++) begin
            int y;
            if ($urandom_range(0, 15) < dens) y = (ry - $urandom_range(0, 70) + YMOD) % YMOD;
            else y = $urandom_range(0, YMOD - 1);
            set_spr(i, y, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3));
            ymem[i][15:14] = 2'($urandom);
        end
    endtask

    // One line: pulse start, optionally restart mid-scan, wait for busy low, check status
    task automatic run_line(input string name, input int ry, input int restart_at, input int ry2);
        int cyc;
        int done;
        int ra;
        ra = restart_at;
        @(negedge clk);
        #1;
        start    = 1'b1;
        render_y = YW'(ry);
        build_expected(ry);
        wr_cnt = 0;
        cyc    = 0;
        done   = 0;
        while (done == 0) begin
            @(negedge clk);
            if (!busy) begin
                done = 1;
            end else begin
                #1;
                if (cyc == 0) begin
                    start    = 1'b0;
                    render_y = YW'($urandom);
                end
                if (ra != 0 && cyc == ra) begin
                    start    = 1'b1;
                    render_y = YW'(ry2);
                    build_expected(ry2);
                    wr_cnt = 0;
                    cyc    = -1;
                    ra     = 0;
                end
                cyc++;
                if (cyc > SC + 10) begin
                    failures++;
                    $display("FAIL %s_timeout busy still high after %0d cycles", name, cyc);
                    done = 2;
                end
            end
        end
        checks++;
        if (cyc > SC + 2 || cyc < 1) begin
            failures++;
            $display("FAIL %s_latency actual=%0d limit=%0d", name, cyc, SC + 2);
        end
        @(negedge clk);
        #1;
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_writes"}, wr_cnt, exp_n + 1);
`ifdef VDP_SPRITE_OVERFLOW_STATUS_EN
        chk({name, "_hit_count"}, int'(hit_count), exp_n);
        chk({name, "_overflow"}, int'(overflow), exp_ovf);
`else
        chk({name, "_hit_count"}, int'(hit_count), 0);
        chk({name, "_overflow"}, int'(overflow), 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        render_y = '0;
        wr_cnt   = 0;
        fill_off(0);
        repeat (3) @(negedge clk);
        chk("rst_meta_addr", int'(bus_if.meta_addr), 0);
        chk("rst_hit_we", int'(bus_if.hit_we), 0);
        chk("rst_hit_addr", int'(bus_if.hit_addr), 0);
        chk("rst_hit_data", int'(bus_if.hit_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_hit_count", int'(hit_count), 0);
        chk("rst_overflow", int'(overflow), 0);
        #1;
        reset = 1'b0;

        // Two hits, second one flipped with height 16
        fill_off(120);
        set_spr(3, 16, 0, 0, 1);
        set_spr(7, 10, 1, 1, 2);
        run_line("two_hits", 20, 0, 0);

        // Empty line: terminator only
        fill_off(300);
        run_line("empty", 40, 0, 0);

        // More hits than the cap
        fill_off(200);
        for (int i = 0; i < 10; i++) set_spr(i, 50, i & 1, 0, i & 3);
        run_line("cap", 50, 0, 0);

        // Wraparound across the top edge, with and without flip
        fill_off(300);
        set_spr(5, 508, 1, 0, 0);
        set_spr(6, 508, 0, 0, 3);
        run_line("wrap", 2, 0, 0);

        // Tallest sprite, last row
        fill_off(300);
        set_spr(2, 0, 0, 3, 1);
        run_line("tall", 63, 0, 0);

        // Restart at scan cycle 40 onto a different line
        fill_off(200);
        set_spr(10, 100, 0, 0, 1);
        set_spr(45, 98, 1, 1, 2);
        set_spr(50, 90, 0, 2, 3);
        set_spr(20, 300, 0, 0, 1);
        set_spr(44, 290, 1, 1, 0);
        set_spr(60, 299, 0, 0, 2);
        run_line("restart", 100, 40, 300);

        // Reset in the middle of a scan
        fill_random(77, 4);
        @(negedge clk);
        #1;
        start    = 1'b1;
        render_y = YW'(77);
        build_expected(77);
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_hit_we", int'(bus_if.hit_we), 0);
        chk("midrst_hit_count", int'(hit_count), 0);
        chk("midrst_overflow", int'(overflow), 0);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_quiet_we", int'(bus_if.hit_we), 0);
        run_line("after_reset", 77, 0, 0);

        // Randomized lines at assorted densities
        for (int it = 0; it < 10; it++) begin
            int ry;
            ry = $urandom_range(0, YMOD - 1);
            fill_random(ry, (it % 4 == 0) ? 1 : (it % 4) * 2);
            run_line("random", ry, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
